// File: rtl/pulse_stretcher.sv
// Stretches single-cycle strobes into fixed-width pulses with a guaranteed low gap.
// Strobes that arrive while busy are queued in a saturating counter and replayed in order.
module pulse_stretcher #(
    parameter int unsigned HIGH_CYCLES = 4,
    parameter int unsigned LOW_CYCLES  = 2,
    parameter int unsigned PEND_W      = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pulse_in,
    input  logic              clr_overflow,
    output logic              pulse_out,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    localparam int unsigned MAX_CYC = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;

    localparam logic [CNT_W-1:0]  HIGH_LOAD = CNT_W'(HIGH_CYCLES - 1);
    localparam logic [CNT_W-1:0]  LOW_LOAD  = CNT_W'(LOW_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ZERO  = '0;
    localparam logic [PEND_W-1:0] PEND_MAX  = '1;
    localparam logic [PEND_W-1:0] PEND_ZERO = '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic [PEND_W-1:0]  pending_next;
    logic               overflow_next;
    logic               pulse_next;
    logic               busy_next;
    logic               pend_inc;
    logic               pend_dec;
    logic               drop;

    // Next-state, cycle counter and backlog bookkeeping.
    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        pend_inc      = 1'b0;
        pend_dec      = 1'b0;
        drop          = 1'b0;
        pending_next  = pending;
        overflow_next = overflow;
        pulse_next    = 1'b0;
        busy_next     = 1'b0;

        case (state)
            IDLE: begin
                cnt_next = CNT_ZERO;
                if (pulse_in) begin
                    state_next = HIGH;
                    cnt_next   = HIGH_LOAD;
                end
            end
            HIGH: begin
                pend_inc = pulse_in;
                if (cnt == CNT_ZERO) begin
                    state_next = GAP;
                    cnt_next   = LOW_LOAD;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            GAP: begin
                pend_inc = pulse_in;
                if (cnt == CNT_ZERO) begin
                    // A strobe on this very edge counts toward the replay decision.
                    if ((pending != PEND_ZERO) || pulse_in) begin
                        state_next = HIGH;
                        cnt_next   = HIGH_LOAD;
                        pend_dec   = 1'b1;
                    end else begin
                        state_next = IDLE;
                        cnt_next   = CNT_ZERO;
                    end
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = CNT_ZERO;
            end
        endcase

        if (pend_inc && !pend_dec) begin
            if (pending == PEND_MAX) begin
                drop = 1'b1;
            end else begin
                pending_next = pending + PEND_W'(1);
            end
        end else if (!pend_inc && pend_dec) begin
            pending_next = pending - PEND_W'(1);
        end

        // Set has priority over clear.
        if (drop) begin
            overflow_next = 1'b1;
        end else if (clr_overflow) begin
            overflow_next = 1'b0;
        end

        pulse_next = (state_next == HIGH);
        busy_next  = (state_next != IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= CNT_ZERO;
            pending   <= PEND_ZERO;
            overflow  <= 1'b0;
            pulse_out <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            pending   <= pending_next;
            overflow  <= overflow_next;
            pulse_out <= pulse_next;
            busy      <= busy_next;
        end
    end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Scoreboard bench for pulse_stretcher: directed per-cycle expectations on two
// configurations (PEND_W=4 and PEND_W=2) plus a random strobe run.
module tb_pulse_stretcher;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pin_a, clr_a, pin_b, clr_b;
    logic       pout_a, busy_a, ovf_a;
    logic       pout_b, busy_b, ovf_b;
    logic [3:0] pend_a;
    logic [1:0] pend_b;

    int total = 0;
    int bad   = 0;
    int sel   = 0;

    typedef struct {
        string tag;
        int    sel;
        int    pulse;
        int    busy;
        int    pend;
        int    ovf;
    } exp_t;

    exp_t expq[$];

    int  strobe_q[$];
    bit  rnd_on    = 1'b0;
    int  cyc_cnt   = 0;
    int  n_strobe  = 0;
    int  n_rise    = 0;

    always #5 clk = ~clk;

    pulse_stretcher #(.HIGH_CYCLES(4), .LOW_CYCLES(2), .PEND_W(4)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .pulse_in(pin_a), .clr_overflow(clr_a),
        .pulse_out(pout_a), .busy(busy_a), .pending(pend_a), .overflow(ovf_a)
    );

    pulse_stretcher #(.HIGH_CYCLES(4), .LOW_CYCLES(2), .PEND_W(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .pulse_in(pin_b), .clr_overflow(clr_b),
        .pulse_out(pout_b), .busy(busy_b), .pending(pend_b), .overflow(ovf_b)
    );

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Drive one cycle of stimulus on the selected DUT and queue what it must show after the edge.
    task automatic cyc(input logic r, input logic p, input logic c,
                       input int ep, input int eb, input int epd, input int eo,
                       input string tag);
        exp_t e;
        @(negedge clk);
        rst_n = r;
        pin_a = (sel == 0) ? p : 1'b0;
        clr_a = (sel == 0) ? c : 1'b0;
        pin_b = (sel == 1) ? p : 1'b0;
        clr_b = (sel == 1) ? c : 1'b0;
        e.tag = tag; e.sel = sel; e.pulse = ep; e.busy = eb; e.pend = epd; e.ovf = eo;
        expq.push_back(e);
    endtask

    task automatic hi_gap(input int pend, input int ovf, input string tag);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 1, 1, pend, ovf, tag);
        for (int i = 0; i < 2; i++) cyc(1, 0, 0, 0, 1, pend, ovf, tag);
    endtask

    // Directed scoreboard: pop one expectation per cycle, just after the edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            if (e.sel == 0) begin
                check({e.tag, ".pulse"},   int'(pout_a), e.pulse);
                check({e.tag, ".busy"},    int'(busy_a), e.busy);
                check({e.tag, ".pending"}, int'(pend_a), e.pend);
                check({e.tag, ".ovf"},     int'(ovf_a),  e.ovf);
            end else begin
                check({e.tag, ".pulse"},   int'(pout_b), e.pulse);
                check({e.tag, ".busy"},    int'(busy_b), e.busy);
                check({e.tag, ".pending"}, int'(pend_b), e.pend);
                check({e.tag, ".ovf"},     int'(ovf_b),  e.ovf);
            end
        end
    end

    // Random-phase monitor: each output rise consumes one queued strobe; run lengths checked.
    logic prev_out = 1'b0;
    int   run      = 0;
    bit   seen     = 1'b0;
    always @(posedge clk) begin
        int t;
        #1;
        cyc_cnt++;
        if (rnd_on) begin
            if (pout_a != prev_out) begin
                if (pout_a) begin
                    if (seen) check("rnd.low_run_ge2", int'(run >= 2), 1);
                    if (strobe_q.size() == 0) begin
                        check("rnd.unexpected_rise", 1, 0);
                    end else begin
                        t = strobe_q.pop_front();
                        check("rnd.rise_after_strobe", int'(t < cyc_cnt), 1);
                    end
                    n_rise++;
                    seen = 1'b1;
                end else begin
                    check("rnd.high_run", run, 4);
                end
                run = 1;
            end else begin
                run++;
            end
            prev_out = pout_a;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        pin_a = 1'b0; clr_a = 1'b0; pin_b = 1'b0; clr_b = 1'b0;

        sel = 0; cyc(0, 0, 0, 0, 0, 0, 0, "reset_a");
        sel = 1; cyc(0, 0, 0, 0, 0, 0, 0, "reset_b");
        sel = 0; cyc(1, 0, 0, 0, 0, 0, 0, "idle_a");

        // Single strobe.
        cyc(1, 1, 0, 1, 1, 0, 0, "single");
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 1, 1, 0, 0, "single.high");
        for (int i = 0; i < 2; i++) cyc(1, 0, 0, 0, 1, 0, 0, "single.gap");
        for (int i = 0; i < 2; i++) cyc(1, 0, 0, 0, 0, 0, 0, "single.idle");

        // Back-to-back strobes.
        cyc(1, 1, 0, 1, 1, 0, 0, "two.s1");
        cyc(1, 1, 0, 1, 1, 1, 0, "two.s2");
        for (int i = 0; i < 2; i++) cyc(1, 0, 0, 1, 1, 1, 0, "two.high1");
        for (int i = 0; i < 2; i++) cyc(1, 0, 0, 0, 1, 1, 0, "two.gap1");
        hi_gap(0, 0, "two.p2");
        cyc(1, 0, 0, 0, 0, 0, 0, "two.idle");

        // Strobe on the last GAP edge.
        cyc(1, 1, 0, 1, 1, 0, 0, "lastgap.s1");
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 1, 1, 0, 0, "lastgap.high1");
        for (int i = 0; i < 2; i++) cyc(1, 0, 0, 0, 1, 0, 0, "lastgap.gap1");
        cyc(1, 1, 0, 1, 1, 0, 0, "lastgap.s2");
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 1, 1, 0, 0, "lastgap.high2");
        for (int i = 0; i < 2; i++) cyc(1, 0, 0, 0, 1, 0, 0, "lastgap.gap2");
        cyc(1, 0, 0, 0, 0, 0, 0, "lastgap.idle");

        // Reset in the middle of a pulse with a backlog.
        cyc(1, 1, 0, 1, 1, 0, 0, "rst.s1");
        cyc(1, 1, 0, 1, 1, 1, 0, "rst.s2");
        cyc(1, 1, 0, 1, 1, 2, 0, "rst.s3");
        cyc(0, 0, 0, 0, 0, 0, 0, "rst.hit");
        for (int i = 0; i < 8; i++) cyc(1, 0, 0, 0, 0, 0, 0, "rst.after");

        // Narrow backlog: saturation, overflow, replay.
        sel = 1;
        cyc(1, 1, 0, 1, 1, 0, 0, "sat.e1");
        cyc(1, 1, 0, 1, 1, 1, 0, "sat.e2");
        cyc(1, 1, 0, 1, 1, 2, 0, "sat.e3");
        cyc(1, 1, 0, 1, 1, 3, 0, "sat.e4");
        cyc(1, 1, 0, 0, 1, 3, 1, "sat.e5_drop");
        cyc(1, 1, 0, 0, 1, 3, 1, "sat.e6_drop");
        hi_gap(2, 1, "sat.p2");
        hi_gap(1, 1, "sat.p3");
        hi_gap(0, 1, "sat.p4");
        cyc(1, 0, 0, 0, 0, 0, 1, "sat.idle");
        cyc(1, 0, 1, 0, 0, 0, 0, "sat.clear");
        cyc(1, 0, 0, 0, 0, 0, 0, "sat.cleared");

        // Clear concurrent with a new drop keeps the flag.
        cyc(1, 1, 0, 1, 1, 0, 0, "setwin.e1");
        cyc(1, 1, 0, 1, 1, 1, 0, "setwin.e2");
        cyc(1, 1, 0, 1, 1, 2, 0, "setwin.e3");
        cyc(1, 1, 0, 1, 1, 3, 0, "setwin.e4");
        cyc(1, 1, 1, 0, 1, 3, 1, "setwin.drop_clr");
        cyc(1, 0, 0, 0, 1, 3, 1, "setwin.gap");
        hi_gap(2, 1, "setwin.p2");
        hi_gap(1, 1, "setwin.p3");
        hi_gap(0, 1, "setwin.p4");
        cyc(1, 0, 1, 0, 0, 0, 0, "setwin.clear");

        // Let the directed queue drain before the random phase.
        sel = 0;
        cyc(1, 0, 0, 0, 0, 0, 0, "pre_rnd");
        @(negedge clk);
        @(negedge clk);

        // Random strobes.
        rnd_on = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            pin_a = ($urandom_range(11) == 0);
            if (pin_a) begin
                strobe_q.push_back(cyc_cnt);
                n_strobe++;
            end
        end
        @(negedge clk);
        pin_a = 1'b0;
        begin
            int k;
            k = 0;
            while (busy_a && k < 400) begin
                @(negedge clk);
                k++;
            end
            check("rnd.drain_done", int'(busy_a), 0);
        end
        @(negedge clk);
        check("rnd.rise_count", n_rise, n_strobe);
        check("rnd.queue_empty", strobe_q.size(), 0);
        check("rnd.no_overflow", int'(ovf_a), 0);
        check("rnd.pending_zero", int'(pend_a), 0);
        rnd_on = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
